// File: rtl/fft_seq_pkg.sv
// Shared types and default framing constants for the analysis-frame path.
`timescale 1ns/1ps
package fft_seq_pkg;

    // Defaults shared with the window and FFT instantiation.
    localparam int unsigned DEF_FRAME_LEN = 1024;
    localparam int unsigned DEF_HOP       = 512;

    typedef logic signed [7:0] sample_t;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        IDLE      = 2'd1,
        STREAM    = 2'd2,
        WAIT_PEAK = 2'd3
    } seq_state_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port circular frame store: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
`timescale 1ns/1ps
module frame_ram
    import fft_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FRAME_LEN,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  sample_t       wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output sample_t       rd_data
);

    sample_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; holds its output while rd_en is low so a stalled beat stays put.
    always_ff @(posedge clk_in) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Cuts the decimated sample stream into overlapping frames, replays each frame
// oldest-first over a valid/ready/last stream and collects the peak result.
`timescale 1ns/1ps
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
    parameter int unsigned HOP          = DEF_HOP,
    parameter int unsigned PEAK_TIMEOUT = 65536,
    parameter int unsigned PEAK_W       = 12
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic signed [7:0] sample_in,
    input  logic              sample_valid_in,
    input  logic              fft_ready_in,
    output logic signed [7:0] out_data,
    output logic              out_valid,
    input  logic              out_ready_in,
    output logic              out_last,
    input  logic [PEAK_W-1:0] peak_in,
    input  logic              peak_valid_in,
    output logic [PEAK_W-1:0] peak_out,
    output logic              peak_valid_out,
    output logic [15:0]       frame_count_out,
    output logic              overrun_out,
    output logic              timeout_out
);

    localparam int unsigned AW = $clog2(FRAME_LEN);
    localparam int unsigned HW = $clog2(HOP + 1);
    localparam int unsigned TW = $clog2(PEAK_TIMEOUT + 1);

    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [HW-1:0] ONE_H    = HW'(1);
    localparam logic [HW-1:0] HOP_C    = HW'(HOP);
    localparam logic [TW-1:0] ONE_T    = TW'(1);
    localparam logic [TW-1:0] TO_C     = TW'(PEAK_TIMEOUT);

    seq_state_t        state_q, state_d;
    logic              en_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     fill_q, fill_d;
    logic [HW-1:0]     hop_q, hop_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;     // frame index of the beat on out_data
    logic [AW-1:0]     wr_since_q, wr_since_d; // frame index the next write would hit
    logic [TW-1:0]     to_q, to_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [PEAK_W-1:0] peak_q, peak_d;
    logic              peak_valid_q, peak_valid_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    sample_t           ram_rd_data;

    logic              sample_req;
    logic              handshake;
    logic              enable_rise;

    assign sample_req  = enable_in && sample_valid_in;
    assign handshake   = out_valid_q && out_ready_in;
    assign enable_rise = enable_in && !en_q;

    frame_ram #(
        .DEPTH (FRAME_LEN),
        .AW    (AW)
    ) u_frame_ram (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // Next-state logic: sample capture, framing FSM, stream pacing and peak collection.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        hop_d        = hop_q;
        base_d       = base_q;
        rd_idx_d     = rd_idx_q;
        wr_since_d   = wr_since_q;
        to_d         = to_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        peak_d       = peak_q;
        peak_valid_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = base_q + rd_idx_q + ONE_A;

        if (enable_rise) begin
            // Restart framing from an empty buffer; any frame in flight is abandoned.
            state_d     = FILL;
            fill_d      = '0;
            wr_ptr_d    = '0;
            hop_d       = '0;
            overrun_d   = 1'b0;
            timeout_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            // While streaming, a write may only reuse a slot whose beat was already accepted.
            if (sample_req) begin
                if (state_q == STREAM && wr_since_q >= rd_idx_q) begin
                    overrun_d = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    if (state_q != FILL && hop_q != HOP_C) begin
                        hop_d = hop_q + ONE_H;
                    end
                    if (state_q == STREAM) begin
                        wr_since_d = wr_since_q + ONE_A;
                    end
                end
            end

            unique case (state_q)
                FILL: begin
                    if (wr_en) begin
                        if (fill_q == LAST_IDX) begin
                            state_d = IDLE;
                            hop_d   = '0;
                        end else begin
                            fill_d = fill_q + ONE_A;
                        end
                    end
                end
                IDLE: begin
                    // Trigger uses pre-write pointers; a same-cycle write counts toward
                    // the next hop and occupies frame slot 0 after it has been read.
                    if (enable_in && hop_q == HOP_C && fft_ready_in) begin
                        state_d     = STREAM;
                        base_d      = wr_ptr_q;
                        rd_en       = 1'b1;
                        rd_addr     = wr_ptr_q;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        hop_d       = wr_en ? ONE_H : '0;
                        wr_since_d  = wr_en ? ONE_A : '0;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (out_last_q) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            to_d        = '0;
                            state_d     = WAIT_PEAK;
                        end else begin
                            rd_en      = 1'b1;
                            rd_idx_d   = rd_idx_q + ONE_A;
                            out_last_d = (rd_idx_q + ONE_A == LAST_IDX);
                        end
                    end
                end
                WAIT_PEAK: begin
                    if (peak_valid_in) begin
                        peak_d       = peak_in;
                        peak_valid_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        state_d      = IDLE;
                    end else if (to_q + ONE_T == TO_C) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        to_d = to_q + ONE_T;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= FILL;
            en_q         <= 1'b0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            hop_q        <= '0;
            base_q       <= '0;
            rd_idx_q     <= '0;
            wr_since_q   <= '0;
            to_q         <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            peak_q       <= '0;
            peak_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_q         <= enable_in;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            hop_q        <= hop_d;
            base_q       <= base_d;
            rd_idx_q     <= rd_idx_d;
            wr_since_q   <= wr_since_d;
            to_q         <= to_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            peak_q       <= peak_d;
            peak_valid_q <= peak_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // RAM output register carries the beat; gating keeps out_data at 0 outside a frame
    // and through reset, since RAM contents are not reset.
    assign out_data        = out_valid_q ? ram_rd_data : '0;
    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign peak_out        = peak_q;
    assign peak_valid_out  = peak_valid_q;
    assign frame_count_out = frame_cnt_q;
    assign overrun_out     = overrun_q;
    assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed-sequence bench with random sample/peak data; a frame model built from the
// history of accepted samples predicts every streamed beat.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
    import fft_seq_pkg::*;

    localparam int unsigned FL = 8;
    localparam int unsigned HP = 4;
    localparam int unsigned PT = 32;
    localparam int unsigned PW = 12;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              enable_in = 1'b0;
    sample_t           sample_in = '0;
    logic              sample_valid_in = 1'b0;
    logic              fft_ready_in = 1'b0;
    logic              out_ready_in = 1'b0;
    logic [PW-1:0]     peak_in = '0;
    logic              peak_valid_in = 1'b0;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic [PW-1:0]     peak_out;
    logic              peak_valid_out;
    logic [15:0]       frame_count_out;
    logic              overrun_out;
    logic              timeout_out;

    always #5 clk_in = ~clk_in;

    fft_frame_sequencer #(
        .FRAME_LEN    (FL),
        .HOP          (HP),
        .PEAK_TIMEOUT (PT),
        .PEAK_W       (PW)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .fft_ready_in    (fft_ready_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready_in    (out_ready_in),
        .out_last        (out_last),
        .peak_in         (peak_in),
        .peak_valid_in   (peak_valid_in),
        .peak_out        (peak_out),
        .peak_valid_out  (peak_valid_out),
        .frame_count_out (frame_count_out),
        .overrun_out     (overrun_out),
        .timeout_out     (timeout_out)
    );

    int      n_cmp = 0;
    int      n_bad = 0;
    int      beats = 0;
    int      lasts = 0;
    sample_t hist[$];
    sample_t expq[$];
    logic    held = 1'b0;
    sample_t held_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic put(input sample_t d, input bit accepted);
        sample_valid_in = 1'b1;
        sample_in       = d;
        tick();
        sample_valid_in = 1'b0;
        if (accepted) hist.push_back(d);
    endtask

    // Expected frame: the newest FL accepted samples, oldest first.
    task automatic load_frame();
        expq.delete();
        for (int i = hist.size() - FL; i < hist.size(); i++) expq.push_back(hist[i]);
    endtask

    task automatic wait_beats(input string tag, input int target, input int limit);
        for (int c = 0; c < limit && beats < target; c++) tick();
        check(tag, beats, target);
    endtask

    task automatic pulse_peak(input logic [PW-1:0] p);
        peak_in       = p;
        peak_valid_in = 1'b1;
        tick();
        peak_valid_in = 1'b0;
    endtask

    // Stream monitor: every accepted beat against the model; stalled beats must hold.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (held) begin
                check("stall_data", out_data, held_data);
                check("stall_valid", out_valid, 1);
            end
            if (out_valid && out_ready_in) begin
                if (expq.size() == 0) begin
                    check("unexpected_beat", out_valid, 0);
                end else begin
                    check("beat_data", out_data, expq[0]);
                    check("beat_last", out_last, expq.size() == 1);
                    void'(expq.pop_front());
                end
                beats++;
                if (out_last) lasts++;
            end
            held      = out_valid && !out_ready_in;
            held_data = out_data;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      k;
        sample_t s;
        logic [PW-1:0] pk;

        // Reset state.
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_peak", peak_out, 0);
        check("rst_peak_valid", peak_valid_out, 0);
        check("rst_frames", frame_count_out, 0);
        check("rst_overrun", overrun_out, 0);
        check("rst_timeout", timeout_out, 0);
        @(posedge clk_in);
        #1;
        rst_in       = 1'b1;
        enable_in    = 1'b1;
        fft_ready_in = 1'b1;
        out_ready_in = 1'b1;
        tick();
        tick();

        // Fill then stream 5..12 back-to-back.
        for (int i = 1; i <= 8; i++) put(sample_t'(i), 1'b1);
        tick();
        tick();
        check("fill_no_beats", beats, 0);
        check("fill_no_valid", out_valid, 0);
        for (int i = 9; i <= 11; i++) put(sample_t'(i), 1'b1);
        put(sample_t'(12), 1'b1);
        load_frame();
        check("trig_t1_valid", out_valid, 0);
        tick();
        check("trig_t2_valid", out_valid, 1);
        check("first_beat", out_data, 5);
        repeat (7) tick();
        check("b2b_last", out_last, 1);
        check("b2b_last_valid", out_valid, 1);
        check("b2b_last_data", out_data, 12);
        tick();
        check("after_last_valid", out_valid, 0);
        check("beats_f1", beats, 8);
        check("lasts_f1", lasts, 1);

        // Peak path, then a stray peak in IDLE.
        pulse_peak(12'h1A3);
        check("peak_strobe", peak_valid_out, 1);
        check("peak_value", peak_out, 12'h1A3);
        check("peak_frames", frame_count_out, 1);
        tick();
        check("peak_strobe_one", peak_valid_out, 0);
        pulse_peak(12'h055);
        check("stray_strobe", peak_valid_out, 0);
        check("stray_value", peak_out, 12'h1A3);
        check("stray_frames", frame_count_out, 1);

        // Backpressure with random data.
        for (int i = 0; i < 3; i++) begin
            s = sample_t'($urandom);
            put(s, 1'b1);
        end
        out_ready_in = 1'b0;
        s = sample_t'($urandom);
        put(s, 1'b1);
        load_frame();
        for (int c = 0; c < 80 && beats < 16; c++) begin
            out_ready_in = ((c % 2) == 1);
            tick();
        end
        out_ready_in = 1'b1;
        check("beats_f2", beats, 16);
        check("lasts_f2", lasts, 2);

        // Peak timeout.
        k = 40;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_out) begin
                k = i;
                break;
            end
        end
        check("timeout_set", timeout_out, 1);
        check("timeout_window", (k >= 31 && k <= 33), 1);
        check("timeout_frames", frame_count_out, 1);

        // Overrun during a stalled stream.
        out_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = sample_t'($urandom);
            put(s, 1'b1);
        end
        load_frame();
        tick();
        check("ovr_pre", overrun_out, 0);
        s = sample_t'($urandom);
        put(s, 1'b0);
        check("ovr_set", overrun_out, 1);
        out_ready_in = 1'b1;
        tick();
        out_ready_in = 1'b0;
        check("ovr_one_beat", beats, 17);
        s = sample_t'($urandom);
        put(s, 1'b1);
        out_ready_in = 1'b1;
        wait_beats("beats_f3", 24, 30);
        pk = PW'($urandom);
        pulse_peak(pk);
        check("peak2_value", peak_out, pk);
        check("peak2_frames", frame_count_out, 2);

        // FFT not ready at hop completion; hop count saturates.
        fft_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s = sample_t'($urandom);
            put(s, 1'b1);
        end
        repeat (4) tick();
        check("nr_no_valid", out_valid, 0);
        check("nr_no_beats", beats, 24);
        load_frame();
        fft_ready_in = 1'b1;
        tick();
        check("nr_valid", out_valid, 1);
        check("nr_first", out_data, expq[0]);
        wait_beats("beats_f4", 32, 20);
        check("lasts_f4", lasts, 4);
        pk = PW'($urandom);
        pulse_peak(pk);
        check("peak3_value", peak_out, pk);
        check("peak3_frames", frame_count_out, 3);

        // Enable toggle clears the sticky flags and refills.
        enable_in = 1'b0;
        tick();
        tick();
        check("en_low_overrun", overrun_out, 1);
        check("en_low_timeout", timeout_out, 1);
        enable_in = 1'b1;
        tick();
        check("en_rise_overrun", overrun_out, 0);
        check("en_rise_timeout", timeout_out, 0);
        hist.delete();
        for (int i = 0; i < 7; i++) begin
            s = sample_t'($urandom);
            put(s, 1'b1);
        end
        tick();
        check("refill_no_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            s = sample_t'($urandom);
            put(s, 1'b1);
        end
        load_frame();
        tick();
        tick();
        tick();
        check("beat3_valid", out_valid, 1);

        // Reset during beat 3.
        rst_in = 1'b0;
        #1;
        expq.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_peak", peak_out, 0);
        check("mid_rst_peak_valid", peak_valid_out, 0);
        check("mid_rst_frames", frame_count_out, 0);
        check("mid_rst_overrun", overrun_out, 0);
        check("mid_rst_timeout", timeout_out, 0);
        check("mid_rst_beats", beats, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
